// File: rtl/proc_pkg.sv
// Shared fetch-path definitions: state encoding, address geometry and program
// start addresses used by the fetch sequencer, ROM and decoder.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int ADDR_W = 10;
  localparam int OFS_W  = 8;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] START0 = 10'd0;
  localparam logic [ADDR_W-1:0] START1 = 10'd256;
  localparam logic [ADDR_W-1:0] START2 = 10'd512;
  localparam logic [ADDR_W-1:0] START3 = 10'd768;

  function automatic logic [ADDR_W-1:0] start_addr(input logic [1:0] sel);
    logic [ADDR_W-1:0] addr;
    case (sel)
      2'd0:    addr = START0;
      2'd1:    addr = START1;
      2'd2:    addr = START2;
      default: addr = START3;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC arithmetic for a RUN cycle (halt is handled by the
// caller). wrap_o flags a sequential increment past the top of the space.
module next_pc
  import proc_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int OW = OFS_W
) (
  input  logic [AW-1:0] pc_i,
  input  logic          stall_i,
  input  logic          branch_en_i,
  input  logic          branch_rel_i,
  input  logic [AW-1:0] target_i,
  input  logic [OW-1:0] offset_i,
  output logic [AW-1:0] next_pc_o,
  output logic          wrap_o
);

  logic [AW-1:0] offset_ext_s;

  assign offset_ext_s = {{(AW-OW){offset_i[OW-1]}}, offset_i};

  // Stall drops any concurrent branch; relative targets wrap silently.
  always_comb begin
    next_pc_o = pc_i;
    wrap_o    = 1'b0;
    if (stall_i) begin
      next_pc_o = pc_i;
    end else if (branch_en_i) begin
      if (branch_rel_i) begin
        next_pc_o = pc_i + offset_ext_s;
      end else begin
        next_pc_o = target_i;
      end
    end else begin
      next_pc_o = pc_i + {{(AW-1){1'b0}}, 1'b1};
      wrap_o    = &pc_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer in front of the instruction ROM: owns the
// Req/Ack handshake, start-address selection, branch/stall/halt and run status.
module fetch_ctrl
  import proc_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req,
  input  logic [1:0]        ProgSel,
  input  logic              Halt,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic              BranchRel,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic [OFS_W-1:0]  BranchOffset,
  output logic [ADDR_W-1:0] InstAddress,
  output logic              InstValid,
  output logic              Ack,
  output logic              Fault,
  output logic [CNT_W-1:0]  CycleCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              ack_q;
  logic              fault_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] pc_d;
  logic              wrap_s;

  next_pc #(.AW(ADDR_W), .OW(OFS_W)) u_next_pc (
    .pc_i         (pc_q),
    .stall_i      (Stall),
    .branch_en_i  (BranchEn),
    .branch_rel_i (BranchRel),
    .target_i     (BranchTarget),
    .offset_i     (BranchOffset),
    .next_pc_o    (pc_d),
    .wrap_o       (wrap_s)
  );

  // Sequencer: halt outranks everything; a sequential wrap ends the run with Fault.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= START0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          pc_q <= start_addr(ProgSel);
          if (Req) begin
            state_q <= RUN;
            cnt_q   <= {CNT_W{1'b0}};
            fault_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
          if (Halt) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end else begin
            pc_q <= pc_d;
            if (wrap_s) begin
              fault_q <= 1'b1;
              state_q <= DONE;
              ack_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!Req) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign InstAddress = pc_q;
  assign InstValid   = (state_q == RUN) && !Stall && !Halt;
  assign Ack         = ack_q;
  assign Fault       = fault_q;
  assign CycleCount  = cnt_q;

endmodule
